// File: rtl/screen_sel_ctl_if.sv
// Mouse, frame-boundary, video source and committed screen-state signals
// exchanged with the PONG screen controller.
interface screen_sel_ctl_if #(
    parameter int DIFF_LEVELS = 2
);
    localparam int DW = (DIFF_LEVELS > 1) ? $clog2(DIFF_LEVELS) : 1;

    logic [11:0]   xpos;
    logic [11:0]   ypos;
    logic          mouse_left;
    logic          button;
    logic          vblnk_in;

    logic          vsync_menu;
    logic          hsync_menu;
    logic [11:0]   rgb_menu;
    logic          vsync_game;
    logic          hsync_game;
    logic [11:0]   rgb_game;
    logic          vsync_cred;
    logic          hsync_cred;
    logic [11:0]   rgb_cred;

    logic          vsync_out;
    logic          hsync_out;
    logic [11:0]   rgb_out;
    logic [1:0]    screen;
    logic [DW-1:0] difficulty;
    logic [11:0]   color1;
    logic [11:0]   color2;

    modport master (
        output xpos, ypos, mouse_left, button, vblnk_in,
        output vsync_menu, hsync_menu, rgb_menu,
        output vsync_game, hsync_game, rgb_game,
        output vsync_cred, hsync_cred, rgb_cred,
        input  vsync_out, hsync_out, rgb_out, screen, difficulty, color1, color2
    );

    modport slave (
        input  xpos, ypos, mouse_left, button, vblnk_in,
        input  vsync_menu, hsync_menu, rgb_menu,
        input  vsync_game, hsync_game, rgb_game,
        input  vsync_cred, hsync_cred, rgb_cred,
        output vsync_out, hsync_out, rgb_out, screen, difficulty, color1, color2
    );
endinterface

// File: rtl/screen_sel_ctl.sv
// PONG screen controller: edge-detected menu clicks raise pending requests
// that are committed on the vblnk rising edge, so the screen, difficulty and
// colour theme only change at a frame boundary. The video outputs are a
// registered mux of the three source pipelines chosen by the committed screen.
module screen_sel_ctl #(
    parameter int NUM_BTN     = 4,
    parameter int BTN_X0      = 362,
    parameter int BTN_X1      = 674,
    parameter int BTN_Y0      = 46,
    parameter int BTN_H       = 100,
    parameter int BTN_PITCH   = 192,
    parameter int DIFF_LEVELS = 2,
    parameter int NUM_THEMES  = 7
) (
    input  logic            clk,
    input  logic            rst,
    screen_sel_ctl_if.slave bus
);
    localparam int DW      = (DIFF_LEVELS > 1) ? $clog2(DIFF_LEVELS) : 1;
    // Only buttons 0..3 carry an action; higher buttons are never decoded.
    localparam int ACT_BTN = (NUM_BTN > 4) ? 4 : NUM_BTN;

    typedef enum logic [1:0] {
        SCR_MENU = 2'd0,
        SCR_GAME = 2'd1,
        SCR_CRED = 2'd2
    } screen_t;

    screen_t       scr_q, scr_d;
    screen_t       req_scr_q, req_scr_d;
    logic          req_vld_q, req_vld_d;
    logic          diff_pend_q, diff_pend_d;
    logic          theme_pend_q, theme_pend_d;
    logic [DW-1:0] diff_q, diff_d;
    logic [2:0]    theme_q, theme_d;

    logic          mouse_prev, button_prev, vblnk_prev;
    logic          click, btn_edge, commit, menu_click, x_in;
    logic [3:0]    btn_hit;

    assign click      = bus.mouse_left & ~mouse_prev;
    assign btn_edge   = bus.button & ~button_prev;
    assign commit     = bus.vblnk_in & ~vblnk_prev;
    assign menu_click = click && (scr_q == SCR_MENU);

    // Edge-detect history; mouse/button history resets high so a level held
    // across reset release is not taken as a fresh press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mouse_prev  <= 1'b1;
            button_prev <= 1'b1;
            vblnk_prev  <= 1'b0;
        end else begin
            mouse_prev  <= bus.mouse_left;
            button_prev <= bus.button;
            vblnk_prev  <= bus.vblnk_in;
        end
    end

    // Inclusive 12-bit hit test of the current pointer against the action buttons.
    always_comb begin
        btn_hit = '0;
        x_in    = (bus.xpos >= 12'(BTN_X0)) && (bus.xpos <= 12'(BTN_X1));
        for (int unsigned k = 0; k < ACT_BTN; k++) begin
            btn_hit[k] = x_in
                && (bus.ypos >= 12'(BTN_Y0 + k * BTN_PITCH))
                && (bus.ypos <= 12'(BTN_Y0 + k * BTN_PITCH + BTN_H));
        end
    end

    // Committed state and pending requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scr_q        <= SCR_MENU;
            req_scr_q    <= SCR_MENU;
            req_vld_q    <= 1'b0;
            diff_pend_q  <= 1'b0;
            theme_pend_q <= 1'b0;
            diff_q       <= '0;
            theme_q      <= '0;
        end else begin
            scr_q        <= scr_d;
            req_scr_q    <= req_scr_d;
            req_vld_q    <= req_vld_d;
            diff_pend_q  <= diff_pend_d;
            theme_pend_q <= theme_pend_d;
            diff_q       <= diff_d;
            theme_q      <= theme_d;
        end
    end

    // Commit pending work at the frame boundary, then merge this cycle's
    // requests so one raised on the commit cycle survives to the next frame.
    always_comb begin
        scr_d        = scr_q;
        req_scr_d    = req_scr_q;
        req_vld_d    = req_vld_q;
        diff_pend_d  = diff_pend_q;
        theme_pend_d = theme_pend_q;
        diff_d       = diff_q;
        theme_d      = theme_q;

        if (commit) begin
            if (req_vld_q) begin
                scr_d = req_scr_q;
            end
            if (diff_pend_q) begin
                diff_d = (diff_q == DW'(DIFF_LEVELS - 1)) ? '0 : diff_q + DW'(1);
            end
            if (theme_pend_q) begin
                theme_d = (theme_q == 3'(NUM_THEMES - 1)) ? '0 : theme_q + 3'd1;
            end
            req_vld_d    = 1'b0;
            diff_pend_d  = 1'b0;
            theme_pend_d = 1'b0;
        end

        if (menu_click) begin
            if (btn_hit[0]) begin
                req_vld_d = 1'b1;
                req_scr_d = SCR_GAME;
            end
            if (btn_hit[1]) begin
                diff_pend_d = 1'b1;
            end
            if (btn_hit[2]) begin
                theme_pend_d = 1'b1;
            end
            if (btn_hit[3]) begin
                req_vld_d = 1'b1;
                req_scr_d = SCR_CRED;
            end
        end else if (btn_edge && (scr_q != SCR_MENU)) begin
            req_vld_d = 1'b1;
            req_scr_d = SCR_MENU;
        end
    end

    // Registered video mux; the unused screen code falls back to the menu source.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.vsync_out <= 1'b0;
            bus.hsync_out <= 1'b0;
            bus.rgb_out   <= '0;
        end else begin
            case (scr_q)
                SCR_GAME: begin
                    bus.vsync_out <= bus.vsync_game;
                    bus.hsync_out <= bus.hsync_game;
                    bus.rgb_out   <= bus.rgb_game;
                end
                SCR_CRED: begin
                    bus.vsync_out <= bus.vsync_cred;
                    bus.hsync_out <= bus.hsync_cred;
                    bus.rgb_out   <= bus.rgb_cred;
                end
                default: begin
                    bus.vsync_out <= bus.vsync_menu;
                    bus.hsync_out <= bus.hsync_menu;
                    bus.rgb_out   <= bus.rgb_menu;
                end
            endcase
        end
    end

    // Theme colour lookup (background / foreground) from the committed theme.
    always_comb begin
        bus.color1 = 12'h000;
        bus.color2 = 12'hFFF;
        case (theme_q)
            3'd1: begin bus.color1 = 12'h099; bus.color2 = 12'hF66; end
            3'd2: begin bus.color1 = 12'h909; bus.color2 = 12'h6F6; end
            3'd3: begin bus.color1 = 12'h990; bus.color2 = 12'h66F; end
            3'd4: begin bus.color1 = 12'h009; bus.color2 = 12'hFF6; end
            3'd5: begin bus.color1 = 12'h900; bus.color2 = 12'h6FF; end
            3'd6: begin bus.color1 = 12'h090; bus.color2 = 12'hF6F; end
            3'd7: begin bus.color1 = 12'h555; bus.color2 = 12'hAAA; end
            default: begin bus.color1 = 12'h000; bus.color2 = 12'hFFF; end
        endcase
    end

    assign bus.screen     = scr_q;
    assign bus.difficulty = diff_q;
endmodule

// File: tb/tb_screen_sel_ctl.sv
// Self-checking bench for screen_sel_ctl: directed test-plan scenarios plus a
// randomized phase, all compared every cycle against a frame-level reference model.
module tb_screen_sel_ctl;
    localparam int NUM_BTN     = 4;
    localparam int BTN_X0      = 362;
    localparam int BTN_X1      = 674;
    localparam int BTN_Y0      = 46;
    localparam int BTN_H       = 100;
    localparam int BTN_PITCH   = 192;
    localparam int DIFF_LEVELS = 2;
    localparam int NUM_THEMES  = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [11:0] theme_c1 [8] = '{12'h000, 12'h099, 12'h909, 12'h990,
                                  12'h009, 12'h900, 12'h090, 12'h555};
    logic [11:0] theme_c2 [8] = '{12'hFFF, 12'hF66, 12'h6F6, 12'h66F,
                                  12'hFF6, 12'h6FF, 12'hF6F, 12'hAAA};

    // Reference model state
    int   m_screen, m_diff, m_theme, m_req;
    bit   m_pd, m_pt, m_mprev, m_bprev, m_vprev;
    logic [13:0] e_video;

    screen_sel_ctl_if #(.DIFF_LEVELS(DIFF_LEVELS)) bus();

    screen_sel_ctl #(
        .NUM_BTN    (NUM_BTN),
        .BTN_X0     (BTN_X0),
        .BTN_X1     (BTN_X1),
        .BTN_Y0     (BTN_Y0),
        .BTN_H      (BTN_H),
        .BTN_PITCH  (BTN_PITCH),
        .DIFF_LEVELS(DIFF_LEVELS),
        .NUM_THEMES (NUM_THEMES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int which_button(input int x, input int y);
        int off;
        if (x < BTN_X0 || x > BTN_X1 || y < BTN_Y0) return -1;
        off = y - BTN_Y0;
        if (off / BTN_PITCH >= NUM_BTN) return -1;
        if (off % BTN_PITCH > BTN_H) return -1;
        return off / BTN_PITCH;
    endfunction

    task automatic model_reset();
        m_screen = 0; m_diff = 0; m_theme = 0; m_req = -1;
        m_pd = 0; m_pt = 0; m_mprev = 1; m_bprev = 1; m_vprev = 0;
        e_video = '0;
    endtask

    task automatic check_state();
        check("screen", 32'(bus.screen), 32'(m_screen));
        check("difficulty", 32'(bus.difficulty), 32'(m_diff));
        check("colors", {8'h0, bus.color1, bus.color2},
              {8'h0, theme_c1[m_theme], theme_c2[m_theme]});
        check("video", {18'h0, bus.vsync_out, bus.hsync_out, bus.rgb_out}, {18'h0, e_video});
    endtask

    // One clock: randomize video sources, predict, clock, compare.
    task automatic step();
        int  b, old_screen;
        bit  ck, be, fr;
        bus.vsync_menu = 1'($urandom); bus.hsync_menu = 1'($urandom); bus.rgb_menu = 12'($urandom);
        bus.vsync_game = 1'($urandom); bus.hsync_game = 1'($urandom); bus.rgb_game = 12'($urandom);
        bus.vsync_cred = 1'($urandom); bus.hsync_cred = 1'($urandom); bus.rgb_cred = 12'($urandom);

        if (m_screen == 1)      e_video = {bus.vsync_game, bus.hsync_game, bus.rgb_game};
        else if (m_screen == 2) e_video = {bus.vsync_cred, bus.hsync_cred, bus.rgb_cred};
        else                    e_video = {bus.vsync_menu, bus.hsync_menu, bus.rgb_menu};

        ck = bus.mouse_left && !m_mprev;
        be = bus.button && !m_bprev;
        fr = bus.vblnk_in && !m_vprev;
        b  = ck ? which_button(int'(bus.xpos), int'(bus.ypos)) : -1;
        old_screen = m_screen;

        if (fr) begin
            if (m_req >= 0) m_screen = m_req;
            if (m_pd) m_diff = (m_diff + 1) % DIFF_LEVELS;
            if (m_pt) m_theme = (m_theme + 1) % NUM_THEMES;
            m_req = -1; m_pd = 0; m_pt = 0;
        end
        if (old_screen == 0) begin
            case (b)
                0: m_req = 1;
                1: m_pd  = 1;
                2: m_pt  = 1;
                3: m_req = 2;
                default: ;
            endcase
        end else if (be) begin
            m_req = 0;
        end
        m_mprev = bus.mouse_left;
        m_bprev = bus.button;
        m_vprev = bus.vblnk_in;

        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic click(input int x, input int y);
        bus.xpos = 12'(x); bus.ypos = 12'(y);
        bus.mouse_left = 1'b1; step();
        bus.mouse_left = 1'b0; step();
    endtask

    task automatic frame();
        bus.vblnk_in = 1'b1; step();
        bus.vblnk_in = 1'b0; step();
    endtask

    task automatic press();
        bus.button = 1'b1; step();
        bus.button = 1'b0; step();
    endtask

    initial begin
        int k, yo;
        bus.xpos = 12'd400; bus.ypos = 12'd90;
        bus.mouse_left = 1'b1; bus.button = 1'b0; bus.vblnk_in = 1'b0;
        bus.vsync_menu = 1'b0; bus.hsync_menu = 1'b0; bus.rgb_menu = '0;
        bus.vsync_game = 1'b0; bus.hsync_game = 1'b0; bus.rgb_game = '0;
        bus.vsync_cred = 1'b0; bus.hsync_cred = 1'b0; bus.rgb_cred = '0;
        model_reset();
        #1 rst = 1'b0;
        #12;
        check("rst_screen", 32'(bus.screen), 32'd0);
        check("rst_difficulty", 32'(bus.difficulty), 32'd0);
        check("rst_colors", {8'h0, bus.color1, bus.color2}, 32'h000FFF);
        check("rst_video", {18'h0, bus.vsync_out, bus.hsync_out, bus.rgb_out}, 32'd0);
        @(negedge clk) rst = 1'b1;

        // Mouse held across reset release: no event
        idle(2); frame(); idle(2); frame(); idle(2);
        check("hold_no_event", 32'(bus.screen), 32'd0);
        bus.mouse_left = 1'b0; step();

        // Corner click selects GAME; button returns to MENU next frame
        click(362, 46); idle(3);
        check("pre_commit_menu", 32'(bus.screen), 32'd0);
        frame();
        check("corner_game", 32'(bus.screen), 32'd1);
        idle(2);
        press(); idle(2);
        check("menu_pending", 32'(bus.screen), 32'd1);
        frame();
        check("button_menu", 32'(bus.screen), 32'd0);

        // Difficulty: three clicks in one frame step once, then wrap
        click(500, 300); click(500, 300); click(500, 300);
        frame();
        check("diff_once", 32'(bus.difficulty), 32'd1);
        click(500, 300); frame();
        check("diff_wrap", 32'(bus.difficulty), 32'd0);
        click(500, 300); frame();
        check("diff_again", 32'(bus.difficulty), 32'd1);

        // Theme stepping through all seven and wrapping
        for (int t = 1; t <= 7; t++) begin
            click(500, 480); frame();
            check("theme_step", {8'h0, bus.color1, bus.color2},
                  {8'h0, theme_c1[t % 7], theme_c2[t % 7]});
        end
        click(500, 480); frame();

        // Misses, credits, and clicks ignored on the credits screen
        click(675, 90); click(500, 147); frame();
        check("miss_screen", 32'(bus.screen), 32'd0);
        check("miss_diff", 32'(bus.difficulty), 32'd1);
        click(500, 650); frame();
        check("credits", 32'(bus.screen), 32'd2);
        click(362, 46); click(500, 300); click(500, 480); frame();
        check("cred_ignore_scr", 32'(bus.screen), 32'd2);
        check("cred_ignore_diff", 32'(bus.difficulty), 32'd1);
        check("cred_ignore_thm", 32'(bus.color1), 32'h099);
        press(); frame();
        check("cred_to_menu", 32'(bus.screen), 32'd0);

        // Click on the commit cycle is deferred, not dropped
        bus.xpos = 12'd500; bus.ypos = 12'd300;
        bus.mouse_left = 1'b1; bus.vblnk_in = 1'b1; step();
        bus.mouse_left = 1'b0; bus.vblnk_in = 1'b0; step();
        check("commit_click_held", 32'(bus.difficulty), 32'd1);
        frame();
        check("commit_click_kept", 32'(bus.difficulty), 32'd0);

        // Asynchronous reset mid-frame discards pending requests
        click(500, 300); frame();
        click(500, 300); click(362, 46); idle(3);
        #2 rst = 1'b0;
        #1;
        check("midrst_screen", 32'(bus.screen), 32'd0);
        check("midrst_difficulty", 32'(bus.difficulty), 32'd0);
        check("midrst_colors", {8'h0, bus.color1, bus.color2}, 32'h000FFF);
        check("midrst_video", {18'h0, bus.vsync_out, bus.hsync_out, bus.rgb_out}, 32'd0);
        model_reset();
        @(negedge clk) rst = 1'b1;
        idle(2); frame(); idle(2);
        check("req_lost_scr", 32'(bus.screen), 32'd0);
        check("req_lost_diff", 32'(bus.difficulty), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 2) == 0) bus.mouse_left = ~bus.mouse_left;
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 4))
                    0: bus.xpos = 12'(BTN_X0 - 1);
                    1: bus.xpos = 12'(BTN_X0);
                    2: bus.xpos = 12'(BTN_X1);
                    3: bus.xpos = 12'(BTN_X1 + 1);
                    default: bus.xpos = 12'($urandom_range(BTN_X0, BTN_X1));
                endcase
                k = int'($urandom_range(0, 5));
                case ($urandom_range(0, 4))
                    0: yo = -1;
                    1: yo = 0;
                    2: yo = BTN_H;
                    3: yo = BTN_H + 1;
                    default: yo = int'($urandom_range(0, BTN_H));
                endcase
                bus.ypos = 12'(BTN_Y0 + k * BTN_PITCH + yo);
            end else begin
                bus.xpos = 12'($urandom);
                bus.ypos = 12'($urandom);
            end
            bus.button = ($urandom_range(0, 29) == 0) ? ~bus.button : bus.button;
            if ($urandom_range(0, 9) == 0) bus.vblnk_in = ~bus.vblnk_in;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
